// File: rtl/encoder_pkg.sv
// Shared constants and helpers for the queued priority encoder.
// Latency: n/a (constants and elaboration-time functions only).
// Backpressure: n/a.
package encoder_pkg;

   // Transfer FSM: IDLE has nothing on offer, HOLD presents out_idx with out_valid high
   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] HOLD = 1'b1;

   // Ceiling log2, used to size the index output from the request count
   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/pri_enc_comb.sv
// Highest-set-bit priority encoder, N request bits to a W-bit index plus any_set.
// Latency: purely combinational.
// Backpressure: none; idx is 0 and any_set is low when vec is all zero.
module pri_enc_comb #(
   parameter int N = 4,
   parameter int W = 2
)(
   input  logic [N-1:0] vec,
   output logic [W-1:0] idx,
   output logic         any_set
);

   // Scan upward so the highest set bit is the last one written and wins
   always_comb begin
      idx     = '0;
      any_set = |vec;
      for (int i = 0; i < N; i++) begin
         if (vec[i]) idx = W'(i);
      end
   end

endmodule

// File: rtl/pri_encoder_4to2_queued.sv
// Latches request pulses and hands out the highest pending index over valid/ready.
// Latency: req at edge k -> pending after k -> out_valid after k+1 (2 cycles from idle).
// Backpressure: out_idx/out_valid hold while out_ready is low; requests keep merging into pending.
module pri_encoder_4to2_queued
   import encoder_pkg::*;
#(
   parameter int N = 4,
   localparam int W = clog2(N)
)(
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] req,
   input  logic         out_ready,
   output logic         out_valid,
   output logic [W-1:0] out_idx,
   output logic [N-1:0] pending,
   output logic         overrun
);

   logic [0:0]   state;
   logic         accept;
   logic [N-1:0] cur_mask;
   logic [N-1:0] clr_mask;
   logic [N-1:0] rem;
   logic [W-1:0] pend_idx;
   logic         pend_any;
   logic [W-1:0] rem_idx;
   logic         rem_any;

   assign out_valid = (state == HOLD);
   assign accept    = out_valid & out_ready;
   // One-hot of the index currently on offer
   assign cur_mask  = {{(N-1){1'b0}}, 1'b1} << out_idx;
   assign clr_mask  = accept ? cur_mask : '0;
   // What is left to serve once the current index is taken (this cycle's req not included)
   assign rem       = pending & ~cur_mask;

   // Selection from idle uses the whole pending set
   pri_enc_comb #(.N(N), .W(W)) u_enc_pend (
      .vec     (pending),
      .idx     (pend_idx),
      .any_set (pend_any)
   );

   // Back-to-back reload picks from what remains after the accepted index
   pri_enc_comb #(.N(N), .W(W)) u_enc_rem (
      .vec     (rem),
      .idx     (rem_idx),
      .any_set (rem_any)
   );

   // Pending set: clear the accepted bit, then OR in new requests so a same-cycle re-request survives
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pending <= '0;
         overrun <= 1'b0;
      end else begin
         pending <= (pending & ~clr_mask) | req;
         if (|(req & pending & ~clr_mask)) overrun <= 1'b1;
      end
   end

   // Transfer FSM: load from pending when idle, hold without preemption, reload or drop after accept
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         out_idx <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (pend_any) begin
                  out_idx <= pend_idx;
                  state   <= HOLD;
               end
            end
            HOLD: begin
               if (out_ready) begin
                  if (rem_any) begin
                     out_idx <= rem_idx;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pri_encoder_4to2_queued.sv
// Bench for pri_encoder_4to2_queued: directed scenarios plus random traffic against a transfer-level model.
// Latency: n/a.
// Backpressure: out_ready driven randomly and by scenario.
module tb_pri_encoder_4to2_queued;

   localparam int N = 4;
   localparam int W = 2;

   logic         clk;
   logic         rst;
   logic [N-1:0] req;
   logic         out_ready;
   logic         out_valid;
   logic [W-1:0] out_idx;
   logic [N-1:0] pending;
   logic         overrun;

   int n_chk;
   int n_pass;

   // Reference model state: set of outstanding requests, the offer, sticky overrun
   int m_pend;
   bit m_valid;
   int m_idx;
   bit m_ovr;

   pri_encoder_4to2_queued #(.N(N)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .out_idx   (out_idx),
      .pending   (pending),
      .overrun   (overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input int exp);
      n_chk++;
      if (got !== exp) begin
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end else begin
         n_pass++;
      end
   endtask

   // Highest set bit of a nonzero value, by arithmetic
   function automatic int highest(input int v);
      return $clog2(v + 1) - 1;
   endfunction

   task automatic check_all(input string tag);
      check({tag, "_vld"}, {31'd0, out_valid}, int'(m_valid));
      check({tag, "_idx"}, {30'd0, out_idx}, m_idx);
      check({tag, "_pend"}, {28'd0, pending}, m_pend);
      check({tag, "_ovr"}, {31'd0, overrun}, int'(m_ovr));
   endtask

   // Advance one model clock: requests merge into the set, the offer is served or replaced
   task automatic model_edge(input int r, input bit rdy);
      int taken;
      int left;
      taken = (m_valid && rdy) ? (1 << m_idx) : 0;
      if ((r & m_pend & ~taken) != 0) m_ovr = 1'b1;
      if (!m_valid) begin
         if (m_pend != 0) begin
            m_idx   = highest(m_pend);
            m_valid = 1'b1;
         end
      end else if (rdy) begin
         left = m_pend & ~(1 << m_idx);
         if (left != 0) m_idx = highest(left);
         else m_valid = 1'b0;
      end
      m_pend = (m_pend & ~taken) | r;
   endtask

   // Drive one cycle of stimulus, clock it, and compare everything against the model
   task automatic step(input int r, input bit rdy, input string tag);
      req       = r[N-1:0];
      out_ready = rdy;
      @(posedge clk);
      model_edge(r, rdy);
      #1;
      check_all(tag);
   endtask

   // Asynchronous reset mid-cycle; outputs must clear with no clock edge
   task automatic do_reset();
      #2;
      rst = 1'b1;
      #1;
      m_pend = 0; m_valid = 1'b0; m_idx = 0; m_ovr = 1'b0;
      check_all("rst");
      @(negedge clk);
      rst       = 1'b0;
      req       = '0;
      out_ready = 1'b0;
   endtask

   initial begin
      int seq[$];
      int cnt0;
      int dec;
      n_chk = 0; n_pass = 0;
      rst = 1'b1; req = '0; out_ready = 1'b0;
      m_pend = 0; m_valid = 1'b0; m_idx = 0; m_ovr = 1'b0;
      #2;
      check_all("por");
      @(negedge clk);
      rst = 1'b0;

      // Single request, consumer stalled: index 2 appears after two edges and holds
      step(4'b0100, 1'b0, "t1_req");
      check("t1_vld_lat1", {31'd0, out_valid}, 0);
      step(0, 1'b0, "t1_lat2");
      check("t1_idx", {30'd0, out_idx}, 2);
      for (int i = 0; i < 5; i++) step(0, 1'b0, "t1_hold");
      check("t1_pend", {28'd0, pending}, 4'b0100);

      // Burst 1011 with ready always high: 3,1,0 back to back
      do_reset();
      step(4'b1011, 1'b1, "t2_req");
      seq.delete();
      for (int i = 0; i < 6; i++) begin
         if (out_valid) seq.push_back(int'(out_idx));
         step(0, 1'b1, "t2_drain");
      end
      check("t2_cnt", seq.size(), 3);
      if (seq.size() == 3) begin
         check("t2_s0", seq[0], 3);
         check("t2_s1", seq[1], 1);
         check("t2_s2", seq[2], 0);
      end
      check("t2_end_pend", {28'd0, pending}, 0);
      check("t2_end_ovr", {31'd0, overrun}, 0);

      // No preemption: holding idx 1, a higher request waits for the accept
      do_reset();
      step(4'b0010, 1'b0, "t3_a");
      step(0, 1'b0, "t3_b");
      step(4'b1000, 1'b0, "t3_hi");
      check("t3_no_preempt", {30'd0, out_idx}, 1);
      step(0, 1'b1, "t3_acc");
      check("t3_next", {30'd0, out_idx}, 3);

      // Re-request on the bit being accepted survives and is not an overrun
      do_reset();
      step(4'b0100, 1'b0, "t4_a");
      step(0, 1'b0, "t4_b");
      step(4'b0100, 1'b1, "t4_acc");
      check("t4_pend2", {31'd0, pending[2]}, 1);
      check("t4_ovr", {31'd0, overrun}, 0);
      for (int i = 0; i < 3; i++) step(0, 1'b0, "t4_again");
      check("t4_reoffer", {30'd0, out_idx}, 2);

      // Repeated pulses on a pending bit merge and flag overrun; only one transfer
      do_reset();
      step(4'b0001, 1'b0, "t5_a");
      step(4'b0001, 1'b0, "t5_b");
      step(4'b0001, 1'b0, "t5_c");
      check("t5_ovr", {31'd0, overrun}, 1);
      cnt0 = 0;
      for (int i = 0; i < 6; i++) begin
         if (out_valid && out_idx == 0) cnt0++;
         step(0, 1'b1, "t5_drain");
      end
      check("t5_one_xfer", cnt0, 1);
      check("t5_ovr_sticky", {31'd0, overrun}, 1);

      // Decoder loopback: one-hot of i must encode back to i
      for (int i = 0; i < N; i++) begin
         do_reset();
         dec = 1 << i;
         step(dec, 1'b0, "lb_a");
         step(0, 1'b0, "lb_b");
         check("lb_idx", {30'd0, out_idx}, i);
      end

      // Reset while holding an offer
      step(4'b0110, 1'b0, "mid_a");
      do_reset();

      // Random traffic, sparse requests and mostly-ready consumer
      for (int i = 0; i < 400; i++) begin
         step(int'($urandom_range(0, 15) & $urandom_range(0, 15)),
              ($urandom_range(0, 3) != 0), "rnd");
      end

      // Random backpressure-heavy phase
      for (int i = 0; i < 200; i++) begin
         step(int'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0), "rnd_bp");
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
